// File: rtl/lcd_host_drv_if.sv
// Host-driver bus bundle: sequencer request side, image ROM port, LCD controller
// command/data channel and window-buffer read port.
interface lcd_host_drv_if;
  logic       req_valid;
  logic [2:0] req_cmd;
  logic       req_ready;
  logic [6:0] img_addr;
  logic [7:0] img_data;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic [7:0] datain;
  logic       busy;
  logic [7:0] dataout;
  logic       output_valid;
  logic [3:0] win_addr;
  logic [7:0] win_data;
  logic       done;
  logic [4:0] beat_cnt;
  logic       err;

  modport master (
    input  req_valid, req_cmd, img_data, busy, dataout, output_valid, win_addr,
    output req_ready, img_addr, cmd, cmd_valid, datain, win_data, done, beat_cnt, err
  );

  modport slave (
    output req_valid, req_cmd, img_data, busy, dataout, output_valid, win_addr,
    input  req_ready, img_addr, cmd, cmd_valid, datain, win_data, done, beat_cnt, err
  );
endinterface

// File: rtl/lcd_host_drv.sv
// Host-side LCD controller driver: issues one command per request, streams the
// image on LOAD, captures returned window beats and reports completion/errors.
module lcd_host_drv #(
  parameter int unsigned IMG_SIZE = 108,
  parameter int unsigned WIN_SIZE = 16,
  parameter int unsigned TIMEOUT  = 1023
) (
  input logic            clk,
  input logic            reset,
  lcd_host_drv_if.master bus
);
  localparam int unsigned PIX_W   = 7;
  localparam int unsigned BEAT_W  = 5;
  localparam int unsigned WADDR_W = 4;
  localparam int unsigned TO_W    = 10;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned OP_W    = 3;

  localparam logic [OP_W-1:0]  OP_LOAD  = OP_W'(0);
  localparam logic [OP_W-1:0]  OP_RSVD  = OP_W'(7);
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(IMG_SIZE - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_LOAD, S_WAIT, S_DONE} state_t;

  state_t              state, state_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [PIX_W-1:0]    pix_q, pix_d;
  logic [TO_W-1:0]     wcnt_q, wcnt_d;
  logic                seen_q, seen_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                err_q, err_d;
  logic [OP_W-1:0]     cmd_q, cmd_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic [DATA_W-1:0]   datain_q, datain_d;
  logic [PIX_W-1:0]    img_addr_q, img_addr_d;
  logic                done_q, done_d;
  logic                win_we;
  logic                req_ready_c;
  logic [DATA_W-1:0]   win [WIN_SIZE];

  assign req_ready_c = (state == S_IDLE) & ~bus.busy & ~err_q;

  // Next-state, counters and next values of all registered outputs
  always_comb begin
    state_d = state;
    op_d    = op_q;
    pix_d   = pix_q;
    wcnt_d  = wcnt_q;
    seen_d  = seen_q;
    beat_d  = beat_q;
    err_d   = err_q;
    win_we  = 1'b0;

    case (state)
      S_IDLE: begin
        if (req_ready_c && bus.req_valid) begin
          if (bus.req_cmd == OP_RSVD) begin
            err_d = 1'b1;
          end else begin
            op_d    = bus.req_cmd;
            beat_d  = '0;
            seen_d  = 1'b0;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        pix_d   = '0;
        wcnt_d  = '0;
        state_d = (op_q == OP_LOAD) ? S_LOAD : S_WAIT;
      end
      S_LOAD: begin
        if (pix_q == LAST_PIX) state_d = S_WAIT;
        else                   pix_d   = pix_q + PIX_W'(1);
      end
      S_WAIT: begin
        wcnt_d = wcnt_q + TO_W'(1);
        if (bus.busy) seen_d = 1'b1;
        // Beats past the buffer depth flag an error and are dropped
        if (bus.output_valid) begin
          if (beat_q < BEAT_W'(WIN_SIZE)) begin
            win_we = 1'b1;
            beat_d = beat_q + BEAT_W'(1);
          end else begin
            err_d = 1'b1;
          end
        end
        if (!bus.busy && seen_q) begin
          state_d = S_DONE;
        end else if (wcnt_q == TO_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    cmd_valid_d = (state_d == S_ISSUE);
    cmd_d       = cmd_valid_d ? bus.req_cmd : '0;
    done_d      = (state_d == S_DONE);
    // ROM is read one address ahead so datain lands on pixel k in LOAD cycle k
    datain_d    = (state_d == S_LOAD) ? bus.img_data : '0;
    img_addr_d  = '0;
    if (state_d == S_LOAD)
      img_addr_d = (pix_d == LAST_PIX) ? LAST_PIX : pix_d + PIX_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      op_q        <= '0;
      pix_q       <= '0;
      wcnt_q      <= '0;
      seen_q      <= 1'b0;
      beat_q      <= '0;
      err_q       <= 1'b0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      datain_q    <= '0;
      img_addr_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_d;
      op_q        <= op_d;
      pix_q       <= pix_d;
      wcnt_q      <= wcnt_d;
      seen_q      <= seen_d;
      beat_q      <= beat_d;
      err_q       <= err_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      datain_q    <= datain_d;
      img_addr_q  <= img_addr_d;
      done_q      <= done_d;
    end
  end

  // Window buffer storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (win_we) win[beat_q[WADDR_W-1:0]] <= bus.dataout;
  end

  assign bus.req_ready = req_ready_c;
  assign bus.win_data  = win[bus.win_addr];
  assign bus.cmd       = cmd_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.datain    = datain_q;
  assign bus.img_addr  = img_addr_q;
  assign bus.done      = done_q;
  assign bus.beat_cnt  = beat_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_lcd_host_drv.sv
// Self-checking bench for lcd_host_drv: table of requests with a controller model,
// plus hand sequences for reset abort, reserved opcode, overflow and timeout.
module tb_lcd_host_drv;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lcd_host_drv_if bus();
  lcd_host_drv dut (.clk(clk), .reset(reset), .bus(bus));

  logic [7:0] rom [128];
  assign bus.img_data = rom[bus.img_addr];

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_win [16];
  logic [7:0] pix_q [$];

  typedef struct {
    logic [2:0] op;
    int         nbeats;
    int         base;
    int         step;
    int         idle;
    int         exp_cnt;
    int         exp_err;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    bus.req_valid    = 1'b0;
    bus.req_cmd      = 3'd0;
    bus.busy         = 1'b0;
    bus.dataout      = 8'd0;
    bus.output_valid = 1'b0;
    bus.win_addr     = 4'd0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // One request through the controller model; starts and ends on a negedge in IDLE
  task automatic run_cmd(input vec_t v);
    int         cnt;
    int         cv_seen;
    logic [7:0] val;
    check("req_ready_idle", 32'(bus.req_ready), 1);
    bus.req_valid = 1'b1;
    bus.req_cmd   = v.op;
    if (v.op == 3'd0)
      for (int k = 0; k < 108; k++) pix_q.push_back(rom[k]);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_cmd   = 3'd0;
    check("cmd_valid_pulse", 32'(bus.cmd_valid), 1);
    check("cmd_opcode", 32'(bus.cmd), 32'(v.op));
    check("img_addr_issue", 32'(bus.img_addr), 0);
    check("req_ready_issue", 32'(bus.req_ready), 0);
    bus.busy = 1'b1;
    cv_seen  = 0;
    if (v.op == 3'd0) begin
      for (int k = 0; k < 108; k++) begin
        @(negedge clk);
        if (bus.cmd_valid) cv_seen++;
        if (pix_q.size() == 0) check("pix_queue_empty", 0, 1);
        else                   check("datain_pixel", 32'(bus.datain), 32'(pix_q.pop_front()));
      end
    end
    @(negedge clk);
    check("datain_wait_zero", 32'(bus.datain), 0);
    cnt = 0;
    bus.win_addr = 4'd0;
    for (int i = 0; i < v.nbeats; i++) begin
      val = 8'(v.base + i * v.step);
      if (cnt < 16) begin
        exp_win[cnt] = val;
        cnt++;
      end
      bus.output_valid = 1'b1;
      bus.dataout      = val;
      @(negedge clk);
      if (bus.cmd_valid) cv_seen++;
      if (i == 0) check("win_next_cycle", 32'(bus.win_data), 32'(exp_win[0]));
    end
    bus.output_valid = 1'b0;
    bus.dataout      = 8'd0;
    repeat (v.idle) @(negedge clk);
    bus.busy = 1'b0;
    @(negedge clk);
    check("cmd_valid_single", 32'(cv_seen), 0);
    check("done_pulse", 32'(bus.done), 1);
    check("beat_cnt", 32'(bus.beat_cnt), 32'(v.exp_cnt));
    check("err_flag", 32'(bus.err), 32'(v.exp_err));
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 0);
    check("req_ready_after", 32'(bus.req_ready), (v.exp_err != 0) ? 0 : 1);
    for (int i = 0; i < 16; i++) begin
      bus.win_addr = 4'(i);
      #1;
      check("win_entry", 32'(bus.win_data), 32'(exp_win[i]));
      @(negedge clk);
    end
  endtask

  initial begin
    int   cv;
    int   dn;
    int   rr;
    vec_t v;

    vecs[0] = '{3'd0, 16, 8'h0D, 3, 1, 16, 0};  // LOAD, beats 0x0D,0x10,...
    vecs[1] = '{3'd1, 16, 8'hA0, 1, 1, 16, 0};  // ZOOM_IN
    vecs[2] = '{3'd3,  0, 8'h00, 0, 3,  0, 0};  // RIGHT, no beats
    vecs[3] = '{3'd2,  5, 8'h30, 2, 0,  5, 0};  // ZOOM_FIT, partial window
    vecs[4] = '{3'd6, 16, 8'h60, 1, 2, 16, 0};  // DOWN
    vecs[5] = '{3'd0, 16, 8'hC1, 1, 1, 16, 0};  // LOAD after reset abort

    for (int k = 0; k < 128; k++) rom[k] = 8'(k);
    for (int i = 0; i < 16; i++) exp_win[i] = 8'h00;

    clear_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cmd_valid", 32'(bus.cmd_valid), 0);
    check("rst_cmd", 32'(bus.cmd), 0);
    check("rst_datain", 32'(bus.datain), 0);
    check("rst_img_addr", 32'(bus.img_addr), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_beat_cnt", 32'(bus.beat_cnt), 0);
    check("rst_err", 32'(bus.err), 0);
    check("rst_req_ready", 32'(bus.req_ready), 1);
    reset = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 5; r++) run_cmd(vecs[r]);

    // Reset asserted in LOAD pixel 50 aborts at once
    bus.req_valid = 1'b1;
    bus.req_cmd   = 3'd0;
    for (int k = 0; k < 108; k++) pix_q.push_back(rom[k]);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.busy      = 1'b1;
    for (int k = 0; k <= 50; k++) begin
      @(negedge clk);
      check("abort_datain", 32'(bus.datain), 32'(pix_q.pop_front()));
    end
    pix_q.delete();
    bus.busy = 1'b0;
    reset    = 1'b0;
    #1;
    check("abort_cmd_valid", 32'(bus.cmd_valid), 0);
    check("abort_cmd", 32'(bus.cmd), 0);
    check("abort_datain_rst", 32'(bus.datain), 0);
    check("abort_img_addr", 32'(bus.img_addr), 0);
    check("abort_done", 32'(bus.done), 0);
    check("abort_beat_cnt", 32'(bus.beat_cnt), 0);
    check("abort_err", 32'(bus.err), 0);
    check("abort_req_ready", 32'(bus.req_ready), 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_cmd(vecs[5]);

    // Reserved opcode: nothing issued, sticky error
    check("rsvd_ready", 32'(bus.req_ready), 1);
    bus.req_valid = 1'b1;
    bus.req_cmd   = 3'd7;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_cmd   = 3'd0;
    cv = 0;
    check("rsvd_err", 32'(bus.err), 1);
    check("rsvd_req_ready", 32'(bus.req_ready), 0);
    for (int i = 0; i < 4; i++) begin
      if (bus.cmd_valid) cv++;
      @(negedge clk);
    end
    check("rsvd_no_cmd", 32'(cv), 0);
    do_reset();
    check("err_cleared_by_reset", 32'(bus.err), 0);

    // 17 beats: 17th dropped, error raised
    v = '{3'd1, 17, 8'h50, 1, 1, 16, 1};
    run_cmd(v);
    do_reset();

    // Controller stuck busy: timeout
    check("to_ready", 32'(bus.req_ready), 1);
    bus.req_valid = 1'b1;
    bus.req_cmd   = 3'd2;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_cmd   = 3'd0;
    check("to_cmd_valid", 32'(bus.cmd_valid), 1);
    bus.busy = 1'b1;
    dn = -1;
    rr = 0;
    for (int t = 1; t <= 1100; t++) begin
      @(negedge clk);
      if (bus.done && dn < 0) dn = t;
      if (bus.req_ready) rr++;
    end
    check("to_done_seen", (dn >= 1020 && dn <= 1028) ? 1 : 0, 1);
    check("to_err", 32'(bus.err), 1);
    check("to_req_ready_low", 32'(rr), 0);
    bus.busy = 1'b0;
    @(negedge clk);
    check("to_req_ready_sticky", 32'(bus.req_ready), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
